periph_rr_arbiter: RTL and testbench
====================================

// Module: periph_rr_arbiter
// PURPOSE
//   Shares one peripheral command port between N_REQ requesters using round-robin arbitration.
//   It serialises transactions:
//     grant -> one-cycle start pulse -> wait for done or timeout -> one-cycle ack.
//   It sits between the TOP-side requesters and the peripheral interface.
// PARAMETERS
//   N_REQ    4    number of requesters (>=2)
//   DW       16   command/response data width
//   TIMEOUT  255  max WAIT cycles before forced completion; 0 = no timeout
// PORTS
//   clk        in   1         clock
//   rst_n      in   1         reset, asynchronous, active-low
//   req        in   N_REQ     per-requester request, held high until its ack
//   req_data   in   N_REQ*DW  packed commands; requester i at [i*DW +: DW]
//   grant      out  N_REQ     one-hot current owner; 0 when idle
//   ack        out  N_REQ     one-cycle completion pulse to the owner
//   err        out  N_REQ     one-cycle timeout flag, coincident with ack
//   rsp_data   out  DW        peripheral response, valid while ack high
//   busy       out  1         high whenever state != IDLE
//   per_start  out  1         one-cycle pulse launching a peripheral op
//   per_data   out  DW        command to peripheral, stable from START to RESP
//   per_done   in   1         peripheral completion pulse
//   per_rdata  in   DW        peripheral response, valid with per_done
// BEHAVIOUR
//   Reset: all outputs 0; state=IDLE; timer=0; rr pointer last=N_REQ-1, so req[0] has first priority.
//   Reset during any state aborts the transaction. No ack is issued for the aborted transaction.
//   Outputs are fully registered.
//   FSM states:
//     IDLE  if |req: select the first set req[i] searching last+1, last+2, ... (mod N_REQ).
//           Register grant=onehot(i) and per_data=req_data[i]; go START.
//           else stay in IDLE.
//     START per_start=1 for exactly this cycle; timer=0; go WAIT.
//           per_done in START is ignored.
//     WAIT  if per_done: capture per_rdata; go RESP with err=0.
//           else if TIMEOUT!=0 and timer==TIMEOUT-1: go RESP with err=1 and rsp_data=0.
//           else timer++.
//           per_done and timeout in the same cycle: done wins, err=0.
//     RESP  ack[i]=1 and err[i]=flag for one cycle; rsp_data valid.
//           Set last=i; clear grant; go IDLE.
//   Handshake:
//     - The requester drops req on the edge where it samples ack=1.
//     - req is sampled only in IDLE, so a still-high req starts a new transaction.
//     - A req dropped while granted does not cancel the transaction; the ack is still pulsed.
//     - req_data[i] must be stable from req rise until sampled in IDLE.
//   Latency:
//     - req high in IDLE cycle n -> grant and per_start in cycle n+1.
//     - per_done in cycle m -> ack in cycle m+1.
//     - Minimum: req high in IDLE cycle n -> ack in cycle n+3.
//   Fairness: a continuously requesting agent waits at most N_REQ-1 transactions.
//   Width rules:
//     - timer is clog2(TIMEOUT+1) bits and never wraps.
//     - The pointer wraps N_REQ-1 -> 0.
//   ack, err and grant bits are never set for more than one requester at a time.
// TESTING
//   1 Single req[2], data 16'h1234; per_done 3 cycles after start with per_rdata=16'hA5A5
//     -> grant=4'b0100 and per_start in cycle 1; per_data=16'h1234;
//        ack=4'b0100, err=0, rsp_data=16'hA5A5 one cycle after per_done.
//   2 req=4'b1111 held, each requester re-raising req after its ack; per_done 1 cycle into WAIT
//     -> grant order 0,1,2,3,0; exactly one ack per transaction; busy low exactly 1 cycle between transactions.
//   3 TIMEOUT=8, req[1], per_done never asserted
//     -> ack[1]=1, err[1]=1, rsp_data=0 after 8 WAIT cycles; next transaction proceeds normally.
//   4 TIMEOUT=8, per_done in the 8th WAIT cycle with per_rdata=16'h00FF
//     -> err=0, rsp_data=16'h00FF; per_done pulsed during START only
//     -> ignored, timeout fires.
//   5 rst_n low during WAIT of requester 1
//     -> all outputs 0 immediately (asynchronous); no ack for requester 1.
//      After release with req=4'b1001 -> req[0] granted first, then req[3].
//   6 req[0] dropped while in WAIT
//     -> transaction completes, ack[0] still pulsed once; no second start for requester 0.

Source files
------------

// File: rtl/periph_rr_arbiter_if.sv
// periph_rr_arbiter_if: requester-side and peripheral-side signals of the round-robin command arbiter
// master is the arbiter's view; slave is the view of whatever drives requests and models the peripheral.
interface periph_rr_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 16
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    ack;
    logic [N_REQ-1:0]    err;
    logic [DW-1:0]       rsp_data;
    logic                busy;
    logic                per_start;
    logic [DW-1:0]       per_data;
    logic                per_done;
    logic [DW-1:0]       per_rdata;

    modport master (
        input  req, req_data, per_done, per_rdata,
        output grant, ack, err, rsp_data, busy, per_start, per_data
    );

    modport slave (
        output req, req_data, per_done, per_rdata,
        input  grant, ack, err, rsp_data, busy, per_start, per_data
    );
endinterface

// File: rtl/periph_rr_arbiter.sv
// periph_rr_arbiter: round-robin sharing of one peripheral command port between N_REQ requesters
// Each transaction runs grant -> start pulse -> wait for done or timeout -> ack; all outputs registered.
module periph_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    periph_rr_arbiter_if.master bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t           r_state, w_state_nx;
    logic [N_REQ-1:0] r_grant, w_grant_nx;
    logic [N_REQ-1:0] r_ack, w_ack_nx;
    logic [N_REQ-1:0] r_err, w_err_nx;
    logic [DW-1:0]    r_rsp, w_rsp_nx;
    logic [DW-1:0]    r_pdata, w_pdata_nx;
    logic             r_busy, w_busy_nx;
    logic             r_start, w_start_nx;
    logic [TW-1:0]    r_timer, w_timer_nx;
    logic [PW-1:0]    r_last, w_last_nx;
    logic [PW-1:0]    r_own, w_own_nx;
    logic [PW-1:0]    w_idx, w_sel;
    logic             w_found;
    logic             w_tmo;

    // First requester after the last owner, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PW'((int'(r_last) + k) % N_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_tmo = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_ack_nx   = '0;
        w_err_nx   = '0;
        w_rsp_nx   = '0;
        w_pdata_nx = r_pdata;
        w_start_nx = 1'b0;
        w_timer_nx = r_timer;
        w_last_nx  = r_last;
        w_own_nx   = r_own;
        case (r_state)
            S_IDLE: if (w_found) begin
                w_state_nx = S_START;
                w_grant_nx = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
                w_pdata_nx = bus.req_data[int'(w_sel)*DW +: DW];
                w_own_nx   = w_sel;
                w_start_nx = 1'b1;
            end
            S_START: begin
                w_state_nx = S_WAIT;
                w_timer_nx = '0;
            end
            S_WAIT: if (bus.per_done) begin
                w_state_nx = S_RESP;
                w_ack_nx   = r_grant;
                w_rsp_nx   = bus.per_rdata;
            end else if (w_tmo) begin
                w_state_nx = S_RESP;
                w_ack_nx   = r_grant;
                w_err_nx   = r_grant;
            end else begin
                w_timer_nx = (r_timer == '1) ? r_timer : r_timer + 1'b1;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_grant_nx = '0;
                w_last_nx  = r_own;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_rsp   <= '0;
            r_pdata <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_timer <= '0;
            r_last  <= PW'(N_REQ - 1);
            r_own   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_ack   <= w_ack_nx;
            r_err   <= w_err_nx;
            r_rsp   <= w_rsp_nx;
            r_pdata <= w_pdata_nx;
            r_busy  <= w_busy_nx;
            r_start <= w_start_nx;
            r_timer <= w_timer_nx;
            r_last  <= w_last_nx;
            r_own   <= w_own_nx;
        end
    end

    assign bus.grant     = r_grant;
    assign bus.ack       = r_ack;
    assign bus.err       = r_err;
    assign bus.rsp_data  = r_rsp;
    assign bus.busy      = r_busy;
    assign bus.per_start = r_start;
    assign bus.per_data  = r_pdata;
endmodule

// File: tb/tb_periph_rr_arbiter.sv
// tb_periph_rr_arbiter: directed scenarios for periph_rr_arbiter with TIMEOUT=8
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_periph_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_mis = 0;

    periph_rr_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    periph_rr_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.req = '0;
        bus.per_done = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        bus.req = '0;
        bus.req_data = '0;
        bus.per_done = 1'b0;
        bus.per_rdata = '0;
        step(2);
        n_vec++; if (bus.grant !== 4'b0 || bus.ack !== 4'b0 || bus.err !== 4'b0) begin n_mis++; $display("FAIL reset_gae: grant=%b ack=%b err=%b want 0", bus.grant, bus.ack, bus.err); end
        n_vec++; if (bus.busy !== 1'b0 || bus.per_start !== 1'b0 || bus.rsp_data !== 16'h0 || bus.per_data !== 16'h0) begin n_mis++; $display("FAIL reset_misc: busy=%b start=%b rsp=%h pdata=%h want 0", bus.busy, bus.per_start, bus.rsp_data, bus.per_data); end
        rst_n = 1'b1;
        step(2);
        n_vec++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        bus.req_data[2*DW +: DW] = 16'h1234;
        bus.req = 4'b0100;
        step(1);
        n_vec++; if (bus.grant !== 4'b0100 || bus.per_start !== 1'b1) begin n_mis++; $display("FAIL single_start: grant=%b start=%b want 0100 1", bus.grant, bus.per_start); end
        n_vec++; if (bus.per_data !== 16'h1234 || bus.busy !== 1'b1) begin n_mis++; $display("FAIL single_pdata: pdata=%h busy=%b want 1234 1", bus.per_data, bus.busy); end
        step(1);
        n_vec++; if (bus.per_start !== 1'b0) begin n_mis++; $display("FAIL single_pulse: start=%b want 0", bus.per_start); end
        step(2);
        bus.per_done = 1'b1;
        bus.per_rdata = 16'hA5A5;
        n_vec++; if (bus.ack !== 4'b0) begin n_mis++; $display("FAIL single_early: ack=%b want 0", bus.ack); end
        step(1);
        bus.per_done = 1'b0;
        n_vec++; if (bus.ack !== 4'b0100 || bus.err !== 4'b0) begin n_mis++; $display("FAIL single_ack: ack=%b err=%b want 0100 0000", bus.ack, bus.err); end
        n_vec++; if (bus.rsp_data !== 16'hA5A5 || bus.per_data !== 16'h1234) begin n_mis++; $display("FAIL single_rsp: rsp=%h pdata=%h want a5a5 1234", bus.rsp_data, bus.per_data); end
        bus.req = 4'b0;
        step(1);
        n_vec++; if (bus.ack !== 4'b0 || bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.rsp_data !== 16'h0) begin n_mis++; $display("FAIL single_idle: ack=%b grant=%b busy=%b rsp=%h want 0", bus.ack, bus.grant, bus.busy, bus.rsp_data); end
        step(1);
        n_vec++; if (bus.busy !== 1'b0 || bus.per_start !== 1'b0) begin n_mis++; $display("FAIL single_rearm: busy=%b start=%b want 0 0", bus.busy, bus.per_start); end
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] oh;
        reset_dut();
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = 16'hC000 + 16'(i);
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            oh = 4'b0001 << exp_seq[t];
            step(1);
            n_vec++; if (bus.grant !== oh || bus.per_start !== 1'b1 || bus.busy !== 1'b1) begin n_mis++; $display("FAIL rr_grant[%0d]: grant=%b start=%b busy=%b want %b 1 1", t, bus.grant, bus.per_start, bus.busy, oh); end
            n_vec++; if (bus.per_data !== 16'hC000 + 16'(exp_seq[t])) begin n_mis++; $display("FAIL rr_pdata[%0d]: got %h want %h", t, bus.per_data, 16'hC000 + 16'(exp_seq[t])); end
            step(1);
            bus.per_done = 1'b1;
            bus.per_rdata = 16'h0B00 + 16'(t);
            step(1);
            bus.per_done = 1'b0;
            n_vec++; if (bus.ack !== oh || bus.err !== 4'b0 || bus.rsp_data !== 16'h0B00 + 16'(t)) begin n_mis++; $display("FAIL rr_ack[%0d]: ack=%b err=%b rsp=%h want %b 0000 %h", t, bus.ack, bus.err, bus.rsp_data, oh, 16'h0B00 + 16'(t)); end
            bus.req[exp_seq[t]] = 1'b0;
            step(1);
            n_vec++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0) begin n_mis++; $display("FAIL rr_gap[%0d]: busy=%b ack=%b want 0 0000", t, bus.busy, bus.ack); end
            if (t < 4) bus.req[exp_seq[t]] = 1'b1;
        end
        bus.req = 4'b0;
        step(1);
        n_vec++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL rr_end: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_timeout();
        bus.req_data[1*DW +: DW] = 16'h5151;
        bus.req = 4'b0010;
        step(2);
        step(7);
        n_vec++; if (bus.ack !== 4'b0 || bus.busy !== 1'b1) begin n_mis++; $display("FAIL tmo_wait8: ack=%b busy=%b want 0000 1", bus.ack, bus.busy); end
        step(1);
        n_vec++; if (bus.ack !== 4'b0010 || bus.err !== 4'b0010 || bus.rsp_data !== 16'h0) begin n_mis++; $display("FAIL tmo_fire: ack=%b err=%b rsp=%h want 0010 0010 0000", bus.ack, bus.err, bus.rsp_data); end
        bus.req = 4'b0;
        step(1);
        n_vec++; if (bus.err !== 4'b0 || bus.busy !== 1'b0) begin n_mis++; $display("FAIL tmo_clear: err=%b busy=%b want 0000 0", bus.err, bus.busy); end
        bus.req = 4'b0010;
        step(2);
        bus.per_done = 1'b1;
        bus.per_rdata = 16'hBEEF;
        step(1);
        bus.per_done = 1'b0;
        n_vec++; if (bus.ack !== 4'b0010 || bus.err !== 4'b0 || bus.rsp_data !== 16'hBEEF) begin n_mis++; $display("FAIL tmo_next: ack=%b err=%b rsp=%h want 0010 0000 beef", bus.ack, bus.err, bus.rsp_data); end
        bus.req = 4'b0;
        step(1);
    endtask

    task automatic test_done_vs_timeout();
        bus.req_data[3*DW +: DW] = 16'h3333;
        bus.req = 4'b1000;
        step(2);
        step(7);
        bus.per_done = 1'b1;
        bus.per_rdata = 16'h00FF;
        step(1);
        bus.per_done = 1'b0;
        n_vec++; if (bus.ack !== 4'b1000 || bus.err !== 4'b0 || bus.rsp_data !== 16'h00FF) begin n_mis++; $display("FAIL edge_done: ack=%b err=%b rsp=%h want 1000 0000 00ff", bus.ack, bus.err, bus.rsp_data); end
        bus.req = 4'b0;
        step(1);
        bus.req_data[0*DW +: DW] = 16'h0A0A;
        bus.req = 4'b0001;
        step(1);
        bus.per_done = 1'b1;
        bus.per_rdata = 16'h1111;
        step(1);
        bus.per_done = 1'b0;
        n_vec++; if (bus.ack !== 4'b0) begin n_mis++; $display("FAIL start_done_ignored: ack=%b want 0000", bus.ack); end
        step(7);
        n_vec++; if (bus.ack !== 4'b0) begin n_mis++; $display("FAIL start_done_wait8: ack=%b want 0000", bus.ack); end
        step(1);
        n_vec++; if (bus.ack !== 4'b0001 || bus.err !== 4'b0001 || bus.rsp_data !== 16'h0) begin n_mis++; $display("FAIL start_done_tmo: ack=%b err=%b rsp=%h want 0001 0001 0000", bus.ack, bus.err, bus.rsp_data); end
        bus.req = 4'b0;
        step(1);
    endtask

    task automatic test_async_reset();
        int n_ack1 = 0;
        bus.req = 4'b0010;
        step(3);
        n_vec++; if (bus.grant !== 4'b0010 || bus.busy !== 1'b1) begin n_mis++; $display("FAIL areset_pre: grant=%b busy=%b want 0010 1", bus.grant, bus.busy); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.per_data !== 16'h0 || bus.ack !== 4'b0) begin n_mis++; $display("FAIL areset_now: grant=%b busy=%b pdata=%h ack=%b want 0", bus.grant, bus.busy, bus.per_data, bus.ack); end
        bus.req = 4'b1001;
        bus.req_data[0*DW +: DW] = 16'h0F0F;
        bus.req_data[3*DW +: DW] = 16'hF3F3;
        step(1);
        rst_n = 1'b1;
        for (int t = 0; t < 2; t++) begin
            step(1);
            if (bus.ack[1] === 1'b1) n_ack1++;
            n_vec++; if (bus.grant !== (t == 0 ? 4'b0001 : 4'b1000)) begin n_mis++; $display("FAIL areset_order[%0d]: grant=%b want %b", t, bus.grant, (t == 0 ? 4'b0001 : 4'b1000)); end
            step(1);
            bus.per_done = 1'b1;
            bus.per_rdata = 16'h7700 + 16'(t);
            step(1);
            bus.per_done = 1'b0;
            if (bus.ack[1] === 1'b1) n_ack1++;
            n_vec++; if (bus.ack !== (t == 0 ? 4'b0001 : 4'b1000)) begin n_mis++; $display("FAIL areset_ack[%0d]: ack=%b want %b", t, bus.ack, (t == 0 ? 4'b0001 : 4'b1000)); end
            bus.req[t == 0 ? 0 : 3] = 1'b0;
            step(1);
        end
        n_vec++; if (n_ack1 !== 0) begin n_mis++; $display("FAIL areset_no_ack1: got %0d acks want 0", n_ack1); end
    endtask

    task automatic test_req_drop();
        int n_ack = 0;
        int n_start = 0;
        bus.req_data[0*DW +: DW] = 16'h0D0D;
        bus.req = 4'b0001;
        step(2);
        bus.req = 4'b0;
        step(2);
        bus.per_done = 1'b1;
        bus.per_rdata = 16'h6666;
        step(1);
        bus.per_done = 1'b0;
        n_vec++; if (bus.ack !== 4'b0001 || bus.rsp_data !== 16'h6666) begin n_mis++; $display("FAIL drop_ack: ack=%b rsp=%h want 0001 6666", bus.ack, bus.rsp_data); end
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (bus.ack !== 4'b0) n_ack++;
            if (bus.per_start === 1'b1) n_start++;
        end
        n_vec++; if (n_ack !== 0 || n_start !== 0) begin n_mis++; $display("FAIL drop_no_restart: acks=%0d starts=%0d want 0 0", n_ack, n_start); end
        n_vec++; if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL drop_idle: busy=%b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_done_vs_timeout();
        test_async_reset();
        test_req_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
